load_store_unit: RTL

//  Memory-stage counterpart to the register file / operand-fetch path.

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding req/ready transaction to data memory.
// It returns load data and the destination register to write-back, and stalls the pipeline while busy.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              isLd,
  input  logic              isSt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stData,
  input  logic [3:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              done,
  output logic              wbEn,
  output logic [DATA_W-1:0] ldResult,
  output logic [3:0]        ldRd,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          rd_q, rd_d;
  logic                is_st_q, is_st_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   ld_result_q, ld_result_d;
  logic [3:0]          ld_rd_q, ld_rd_d;

  // NOTE: every signal written here gets a default first; otherwise a path
  // that skips an assignment infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    is_st_d     = is_st_q;
    err_d       = 1'b0;
    ld_result_d = ld_result_q;
    ld_rd_d     = ld_rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (isLd && isSt) begin
            err_d = 1'b1;
          end else if (isLd || isSt) begin
            if (addr[1:0] != 2'b00) begin
              err_d = 1'b1;
            end else begin
              addr_d  = addr;
              wdata_d = isSt ? stData : '0;
              rd_d    = rd;
              is_st_d = isSt;
              cnt_d   = '0;
              state_d = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          if (!is_st_q) begin
            ld_result_d = mem_rdata;
            ld_rd_d     = rd_q;
          end
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Memory never answered: abandon the request and flag it.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      is_st_q     <= 1'b0;
      err_q       <= 1'b0;
      ld_result_q <= '0;
      ld_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      is_st_q     <= is_st_d;
      err_q       <= err_d;
      ld_result_q <= ld_result_d;
      ld_rd_q     <= ld_rd_d;
    end
  end

  // Memory-side outputs are forced to zero outside REQ so idle buses stay quiet.
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & is_st_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  assign stall     = (state_q == S_REQ) | (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign wbEn      = done & ~is_st_q;
  assign ldResult  = ld_result_q;
  assign ldRd      = ld_rd_q;
  assign err       = err_q;

endmodule
